// File: rtl/tcu_fedp_sequencer.sv
// Sequences a K-step dot-product job through one fused dot-product unit,
// feeding each FEDP result back as the next step's C operand.
module tcu_fedp_sequencer #(
  parameter int unsigned N            = 1,
  parameter int unsigned FEDP_LATENCY = 10,
  parameter int unsigned KW           = 4,
  parameter int unsigned TAGW         = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_fmt_s,
  input  logic [2:0]        req_fmt_d,
  input  logic [KW-1:0]     req_ksteps,
  input  logic [31:0]       req_c,
  input  logic [TAGW-1:0]   req_tag,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [N*32-1:0]   op_a,
  input  logic [N*32-1:0]   op_b,
  output logic              fedp_enable,
  output logic [2:0]        fedp_fmt_s,
  output logic [2:0]        fedp_fmt_d,
  output logic [N*32-1:0]   fedp_a_row,
  output logic [N*32-1:0]   fedp_b_col,
  output logic [31:0]       fedp_c_val,
  input  logic [31:0]       fedp_d_val,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_d,
  output logic [TAGW-1:0]   rsp_tag,
  output logic              rsp_err
);

  localparam int unsigned DW = N * 32;
  localparam int unsigned CW = $clog2(FEDP_LATENCY + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              op_ready_q, op_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              en_q, en_d;
  logic [2:0]        fmt_s_q, fmt_s_d;
  logic [2:0]        fmt_d_q, fmt_d_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic [KW-1:0]     steps_q, steps_d;
  logic [CW-1:0]     wait_q, wait_d;
  logic [31:0]       acc_q, acc_d;
  logic              err_q, err_d;
  logic [DW-1:0]     a_q, a_d;
  logic [DW-1:0]     b_q, b_d;
  logic [31:0]       c_q, c_d;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    en_d    = 1'b1;
    fmt_s_d = fmt_s_q;
    fmt_d_d = fmt_d_q;
    tag_d   = tag_q;
    steps_d = steps_q;
    wait_d  = wait_q;
    acc_d   = acc_q;
    err_d   = err_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          fmt_s_d = req_fmt_s;
          fmt_d_d = req_fmt_d;
          tag_d   = req_tag;
          steps_d = req_ksteps;
          acc_d   = req_c;
          err_d   = !(req_fmt_s inside {3'd1, 3'd2, 3'd3});
          state_d = (req_ksteps == KW'(0)) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_valid && op_ready_q) begin
          a_d     = op_a;
          b_d     = op_b;
          c_d     = acc_q;
          wait_d  = CW'(FEDP_LATENCY);
          steps_d = steps_q - KW'(1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Capture only in the cycle the issued operands reach d_val
        if (wait_q == CW'(0)) begin
          acc_d   = err_q ? 32'd0 : fedp_d_val;
          state_d = (steps_q == KW'(0)) ? S_RESP : S_ISSUE;
        end else begin
          wait_d = wait_q - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready && rsp_valid_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    op_ready_d  = (state_d == S_ISSUE);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      op_ready_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      en_q        <= 1'b0;
      fmt_s_q     <= 3'd0;
      fmt_d_q     <= 3'd0;
      tag_q       <= '0;
      steps_q     <= '0;
      wait_q      <= '0;
      acc_q       <= 32'd0;
      err_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 32'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      op_ready_q  <= op_ready_d;
      rsp_valid_q <= rsp_valid_d;
      en_q        <= en_d;
      fmt_s_q     <= fmt_s_d;
      fmt_d_q     <= fmt_d_d;
      tag_q       <= tag_d;
      steps_q     <= steps_d;
      wait_q      <= wait_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign op_ready    = op_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign fedp_enable = en_q;
  assign fedp_fmt_s  = fmt_s_q;
  assign fedp_fmt_d  = fmt_d_q;
  assign fedp_a_row  = a_q;
  assign fedp_b_col  = b_q;
  assign fedp_c_val  = c_q;
  assign rsp_d       = acc_q;
  assign rsp_tag     = tag_q;
  assign rsp_err     = err_q;

endmodule

// File: tb/tb_tcu_fedp_sequencer.sv
// Bench for tcu_fedp_sequencer: a stub FEDP pipeline plus a job-level
// reference model that folds the step results over the operand list.
module tb_tcu_fedp_sequencer;

  localparam int unsigned N    = 1;
  localparam int unsigned LAT  = 10;
  localparam int unsigned KW   = 4;
  localparam int unsigned TAGW = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            req_valid, req_ready;
  logic [2:0]      req_fmt_s, req_fmt_d;
  logic [KW-1:0]   req_ksteps;
  logic [31:0]     req_c;
  logic [TAGW-1:0] req_tag;
  logic            op_valid, op_ready;
  logic [N*32-1:0] op_a, op_b;
  logic            fedp_enable;
  logic [2:0]      fedp_fmt_s, fedp_fmt_d;
  logic [N*32-1:0] fedp_a_row, fedp_b_col;
  logic [31:0]     fedp_c_val, fedp_d_val;
  logic            rsp_valid, rsp_ready;
  logic [31:0]     rsp_d;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tcu_fedp_sequencer #(.N(N), .FEDP_LATENCY(LAT), .KW(KW), .TAGW(TAGW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_fmt_s(req_fmt_s),
    .req_fmt_d(req_fmt_d), .req_ksteps(req_ksteps), .req_c(req_c), .req_tag(req_tag),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .fedp_enable(fedp_enable), .fedp_fmt_s(fedp_fmt_s), .fedp_fmt_d(fedp_fmt_d),
    .fedp_a_row(fedp_a_row), .fedp_b_col(fedp_b_col), .fedp_c_val(fedp_c_val),
    .fedp_d_val(fedp_d_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_d(rsp_d),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  // ---------------- numeric helpers for the stub FEDP ----------------
  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real r;
    if (h[14:10] == 5'd0) return 0.0;
    r = (1.0 + real'(h[9:0]) / 1024.0) * pow2(int'(h[14:10]) - 15);
    return h[15] ? -r : r;
  endfunction

  function automatic real f2r(input logic [31:0] f);
    real r;
    if (f[30:23] == 8'd0) return 0.0;
    r = (1.0 + real'(f[22:0]) / 8388608.0) * pow2(int'(f[30:23]) - 127);
    return f[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] bits;
    int e;
    if (r == 0.0) return 32'd0;
    bits = $realtobits(r);
    e = int'(bits[62:52]) - 1023 + 127;
    return {bits[63], e[7:0], bits[51:29]};
  endfunction

  // One FEDP step: fp16 is a real two-lane dot product, other formats a hash
  function automatic logic [31:0] fedp_fn(input logic [2:0] fmt, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c);
    if (fmt == 3'd1)
      return r2f(h2r(a[15:0]) * h2r(b[15:0]) + h2r(a[31:16]) * h2r(b[31:16]) + f2r(c));
    return ((a * 32'd3) ^ b) + c + {29'd0, fmt};
  endfunction

  // Stub FEDP: free-running pipeline, result LAT cycles after inputs change
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    if (fedp_enable) begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= fedp_fn(fedp_fmt_s, fedp_a_row, fedp_b_col, fedp_c_val);
    end
  end
  assign fedp_d_val = pipe[LAT-1];

  // ---------------- reference model ----------------
  logic [31:0] ja[$];
  logic [31:0] jb[$];

  function automatic logic [31:0] model_job(input logic [2:0] fmt, input int k,
                                            input logic [31:0] c);
    logic [31:0] acc = c;
    if (!(fmt inside {3'd1, 3'd2, 3'd3}) && k > 0) return 32'd0;
    for (int i = 0; i < k; i++) acc = fedp_fn(fmt, ja[i], jb[i], acc);
    return acc;
  endfunction

  function automatic logic [15:0] pick_h();
    case ($urandom_range(0, 4))
      0: return 16'h0000;
      1: return 16'h3C00;
      2: return 16'h4000;
      3: return 16'h4200;
      default: return 16'h3800;
    endcase
  endfunction

  task automatic fill_ops(input logic [2:0] fmt, input int k);
    ja.delete(); jb.delete();
    for (int i = 0; i < k; i++) begin
      if (fmt == 3'd1) begin
        ja.push_back({pick_h(), pick_h()});
        jb.push_back({pick_h(), pick_h()});
      end else begin
        ja.push_back($urandom);
        jb.push_back($urandom);
      end
    end
  endtask

  // ---------------- job driver (records observations) ----------------
  logic [31:0]     r_d;
  logic [TAGW-1:0] r_tag;
  logic            r_err;
  int              r_beats, r_req_cyc, r_rsp_cyc;
  int              hs_cyc[$];
  logic [31:0]     cval[$];
  bit              r_ok, r_stable, r_rr_low, r_after_ok, r_fmt_ok;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_job(input logic [2:0] fs, input logic [2:0] fd, input int k,
                        input logic [31:0] c, input logic [TAGW-1:0] tag, input int delay);
    int t = 0;
    int w = 0;
    bit got = 0;
    bit pending = 0;
    r_ok = 0; r_stable = 1; r_rr_low = 1; r_after_ok = 0; r_fmt_ok = 1;
    r_beats = 0; hs_cyc.delete(); cval.delete();
    while (!req_ready && t < 50) begin tick(); t++; end
    if (!req_ready) return;
    req_valid = 1; req_fmt_s = fs; req_fmt_d = fd;
    req_ksteps = KW'(k); req_c = c; req_tag = tag;
    r_req_cyc = cyc;
    tick();
    req_valid = 0;
    for (t = 0; t < 3000; t++) begin
      if (pending) begin
        cval.push_back(fedp_c_val);
        if (fedp_fmt_s !== fs || fedp_fmt_d !== fd) r_fmt_ok = 0;
        pending = 0;
      end
      if (rsp_valid) begin
        if (!got) begin
          got = 1; r_d = rsp_d; r_tag = rsp_tag; r_err = rsp_err; r_rsp_cyc = cyc;
        end else if (rsp_d !== r_d || rsp_tag !== r_tag || rsp_err !== r_err) begin
          r_stable = 0;
        end
        if (req_ready) r_rr_low = 0;
        if (w >= delay) begin
          rsp_ready = 1;
          tick();
          rsp_ready = 0;
          op_valid = 0;
          r_after_ok = !rsp_valid && req_ready;
          r_ok = 1;
          return;
        end
        w++;
      end
      op_valid = 1;
      op_a = (r_beats < k) ? ja[r_beats] : $urandom;
      op_b = (r_beats < k) ? jb[r_beats] : $urandom;
      if (op_ready) begin
        hs_cyc.push_back(cyc);
        r_beats++;
        pending = 1;
      end
      tick();
    end
    op_valid = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 0; req_valid = 0; op_valid = 0; rsp_ready = 0;
    req_fmt_s = 0; req_fmt_d = 0; req_ksteps = 0; req_c = 0; req_tag = 0;
    op_a = 0; op_b = 0;
    #1;
    checks++; if (op_ready !== 1'b0) begin failures++; $display("FAIL reset_op_ready got=%b exp=0", op_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (fedp_enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", fedp_enable); end
    checks++; if (rsp_d !== 32'd0 || fedp_c_val !== 32'd0) begin failures++; $display("FAIL reset_datapath rsp_d=%h c=%h exp=0", rsp_d, fedp_c_val); end
    repeat (3) @(posedge clk);
    #3 reset_n = 1;
    tick();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (fedp_enable !== 1'b1) begin failures++; $display("FAIL post_reset_enable got=%b exp=1", fedp_enable); end
  endtask

  task automatic test_fp16_single();
    ja = '{32'h3C003C00}; jb = '{32'h40004000};
    do_job(3'd1, 3'd2, 1, 32'h3F800000, 8'h11, 0);
    checks++; if (!r_ok) begin failures++; $display("FAIL single_timeout"); return; end
    checks++; if (r_d !== 32'h40A00000) begin failures++; $display("FAIL single_d got=%h exp=40a00000", r_d); end
    checks++; if (r_err !== 1'b0 || r_tag !== 8'h11) begin failures++; $display("FAIL single_tag_err got=%h/%b exp=11/0", r_tag, r_err); end
    checks++; if (r_beats != 1) begin failures++; $display("FAIL single_beats got=%0d exp=1", r_beats); end
    checks++; if (r_rsp_cyc - hs_cyc[0] != LAT + 2) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", r_rsp_cyc - hs_cyc[0], LAT + 2); end
    checks++; if (cval[0] !== 32'h3F800000) begin failures++; $display("FAIL single_c_val got=%h exp=3f800000", cval[0]); end
    checks++; if (!r_fmt_ok) begin failures++; $display("FAIL single_fmt_held got=0 exp=1"); end
  endtask

  task automatic test_fp16_two();
    ja = '{32'h3C003C00, 32'h3C003C00}; jb = '{32'h40004000, 32'h40004000};
    do_job(3'd1, 3'd1, 2, 32'h3F800000, 8'h22, 0);
    checks++; if (!r_ok) begin failures++; $display("FAIL two_timeout"); return; end
    checks++; if (r_beats != 2) begin failures++; $display("FAIL two_beats got=%0d exp=2", r_beats); return; end
    checks++; if (hs_cyc[1] - hs_cyc[0] != LAT + 2) begin failures++; $display("FAIL two_spacing got=%0d exp=%0d", hs_cyc[1] - hs_cyc[0], LAT + 2); end
    checks++; if (cval[1] !== 32'h40A00000) begin failures++; $display("FAIL two_c_val got=%h exp=40a00000", cval[1]); end
    checks++; if (r_d !== 32'h41100000) begin failures++; $display("FAIL two_d got=%h exp=41100000", r_d); end
  endtask

  task automatic test_zero_steps();
    ja.delete(); jb.delete();
    do_job(3'd2, 3'd1, 0, 32'h12345678, 8'h5A, 0);
    checks++; if (!r_ok) begin failures++; $display("FAIL zero_timeout"); return; end
    checks++; if (r_beats != 0) begin failures++; $display("FAIL zero_beats got=%0d exp=0", r_beats); end
    checks++; if (r_rsp_cyc - r_req_cyc != 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", r_rsp_cyc - r_req_cyc); end
    checks++; if (r_d !== 32'h12345678 || r_tag !== 8'h5A || r_err !== 1'b0) begin failures++; $display("FAIL zero_rsp got=%h/%h/%b exp=12345678/5a/0", r_d, r_tag, r_err); end
  endtask

  task automatic test_bad_fmt();
    fill_ops(3'd0, 3);
    do_job(3'd0, 3'd1, 3, 32'h3F800000, 8'h33, 0);
    checks++; if (!r_ok) begin failures++; $display("FAIL badfmt_timeout"); return; end
    checks++; if (r_beats != 3) begin failures++; $display("FAIL badfmt_beats got=%0d exp=3", r_beats); end
    checks++; if (r_d !== 32'd0 || r_err !== 1'b1) begin failures++; $display("FAIL badfmt_rsp got=%h/%b exp=0/1", r_d, r_err); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    fill_ops(3'd3, 1);
    exp = model_job(3'd3, 1, 32'hCAFE0001);
    do_job(3'd3, 3'd4, 1, 32'hCAFE0001, 8'h44, 5);
    checks++; if (!r_ok) begin failures++; $display("FAIL bp_timeout"); return; end
    checks++; if (!r_stable) begin failures++; $display("FAIL bp_stable got=0 exp=1"); end
    checks++; if (!r_rr_low) begin failures++; $display("FAIL bp_req_ready_low got=0 exp=1"); end
    checks++; if (!r_after_ok) begin failures++; $display("FAIL bp_release got=0 exp=1"); end
    checks++; if (r_d !== exp) begin failures++; $display("FAIL bp_d got=%h exp=%h", r_d, exp); end
  endtask

  task automatic test_reset_mid_job();
    int t = 0;
    bit seen = 0;
    while (!req_ready && t < 50) begin tick(); t++; end
    req_valid = 1; req_fmt_s = 3'd1; req_fmt_d = 3'd1; req_ksteps = KW'(2);
    req_c = 32'h3F800000; req_tag = 8'h66;
    tick();
    req_valid = 0;
    t = 0;
    while (!op_ready && t < 50) begin tick(); t++; end
    op_valid = 1; op_a = 32'h3C003C00; op_b = 32'h40004000;
    tick();
    op_valid = 0;
    repeat (5) tick();
    reset_n = 0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || op_ready !== 1'b0) begin failures++; $display("FAIL midrst_handshake got=%b/%b exp=0/0", rsp_valid, op_ready); end
    checks++; if (fedp_enable !== 1'b0 || fedp_c_val !== 32'd0 || rsp_d !== 32'd0) begin failures++; $display("FAIL midrst_clear en=%b c=%h d=%h exp=0", fedp_enable, fedp_c_val, rsp_d); end
    #2 reset_n = 1;
    for (int i = 0; i < 20; i++) begin tick(); if (rsp_valid || op_ready) seen = 1; end
    checks++; if (seen) begin failures++; $display("FAIL midrst_no_rsp got=1 exp=0"); end
    ja = '{32'h3C003C00}; jb = '{32'h40004000};
    do_job(3'd1, 3'd1, 1, 32'h3F800000, 8'h77, 0);
    checks++; if (!r_ok || r_d !== 32'h40A00000 || r_tag !== 8'h77) begin failures++; $display("FAIL midrst_next_job ok=%b d=%h tag=%h exp=1/40a00000/77", r_ok, r_d, r_tag); end
  endtask

  task automatic test_max_steps();
    logic [31:0] exp;
    fill_ops(3'd1, 15);
    exp = model_job(3'd1, 15, 32'h3F800000);
    do_job(3'd1, 3'd1, 15, 32'h3F800000, 8'h88, 1);
    checks++; if (!r_ok) begin failures++; $display("FAIL max_timeout"); return; end
    checks++; if (r_beats != 15) begin failures++; $display("FAIL max_beats got=%0d exp=15", r_beats); end
    checks++; if (r_d !== exp) begin failures++; $display("FAIL max_d got=%h exp=%h", r_d, exp); end
  endtask

  task automatic test_random();
    for (int j = 0; j < 12; j++) begin
      logic [2:0] fs = 3'($urandom_range(0, 3));
      logic [2:0] fd = 3'($urandom);
      int k = $urandom_range(0, 6);
      logic [31:0] c = (fs == 3'd1) ? 32'h40000000 : $urandom;
      logic [7:0] tag = 8'($urandom);
      logic [31:0] exp;
      if (fs == 3'd0 && k == 0) k = 2;
      fill_ops(fs, k);
      exp = model_job(fs, k, c);
      do_job(fs, fd, k, c, tag, $urandom_range(0, 3));
      checks++;
      if (!r_ok || r_d !== exp || r_tag !== tag || r_err !== (fs == 3'd0) || r_beats != k
          || !r_after_ok || !r_fmt_ok) begin
        failures++;
        $display("FAIL random_job%0d ok=%b d=%h tag=%h err=%b beats=%0d fmt=%b exp d=%h tag=%h err=%b beats=%0d",
                 j, r_ok, r_d, r_tag, r_err, r_beats, r_fmt_ok, exp, tag, (fs == 3'd0), k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fp16_single();
    test_fp16_two();
    test_zero_steps();
    test_bad_fmt();
    test_backpressure();
    test_reset_mid_job();
    test_max_steps();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
